// File: rtl/dct_pkg.sv
// Shared definitions for the 2-D DCT sequencing logic: row geometry,
// default engine timing and the row-issue FSM encoding.
package dct_pkg;

  localparam int ROW_W        = 96;  // 8 pixels x 12 bit
  localparam int ROW_GAP      = 8;   // row-stage DCT issue period in cycles
  localparam int MAX_INFLIGHT = 2;   // ping-pong transpose banks
  localparam int BLK_CNT_W    = 16;
  localparam int ROWS_PER_BLK = 8;
  localparam int ROW_IDX_W    = $clog2(ROWS_PER_BLK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SPACE = 2'd2
  } seq_state_e;

  // Row index within a block, wrapping after the last row.
  function automatic logic [ROW_IDX_W-1:0] next_row(input logic [ROW_IDX_W-1:0] idx);
    if (idx == ROW_IDX_W'(ROWS_PER_BLK - 1)) begin
      return '0;
    end
    return idx + ROW_IDX_W'(1);
  endfunction

endpackage

// File: rtl/dct_blk_credit.sv
// Block credit tracker: counts blocks opened by the producer side and not
// yet closed by the consumer side. A consumer beat arriving with nothing in
// flight is an accounting error and raises a sticky flag instead of letting
// the counter underflow.
module dct_blk_credit
  import dct_pkg::*;
#(
  parameter int MAX_BLK = MAX_INFLIGHT,
  parameter int CNT_W   = $clog2(MAX_BLK + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             blk_open,
  input  logic             blk_close,
  input  logic             consume_evt,
  output logic [CNT_W-1:0] inflight,
  output logic             credit_avail,
  output logic             has_blk,
  output logic             err_ovf
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BLK);

  logic close_ok;

  assign has_blk      = (inflight != '0);
  assign credit_avail = (inflight < MAX_CNT);
  assign close_ok     = blk_close && has_blk;

  // Open and close on the same edge cancel; closes with nothing open are dropped.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      inflight <= '0;
      err_ovf  <= 1'b0;
    end else begin
      if (blk_open && !close_ok) begin
        inflight <= inflight + CNT_W'(1);
      end else if (close_ok && !blk_open) begin
        inflight <= inflight - CNT_W'(1);
      end
      if (consume_evt && !has_blk) begin
        err_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dct_2d_seq_ctrl.sv
// Sequencer for the row DCT -> transpose -> column DCT chain. Accepts rows
// from upstream, issues them to the row engine at its row period, and keeps
// whole blocks in flight within the transpose bank count.
//
// state | meaning
// IDLE  | no transpose bank free for a new block; hold off upstream
// ISSUE | ready for a row; waits here indefinitely for in_valid
// SPACE | row just issued; counting down the row-engine period
module dct_2d_seq_ctrl #(
  parameter int ROW_W        = dct_pkg::ROW_W,
  parameter int ROW_GAP      = dct_pkg::ROW_GAP,
  parameter int MAX_INFLIGHT = dct_pkg::MAX_INFLIGHT,
  parameter int BLK_CNT_W    = dct_pkg::BLK_CNT_W
) (
  input  logic                                  sys_clk,
  input  logic                                  sys_rst_n,
  input  logic                                  in_valid,
  input  logic [ROW_W-1:0]                      in_data,
  output logic                                  in_ready,
  output logic                                  dct_start,
  output logic [ROW_W-1:0]                      dct_data,
  input  logic                                  col_en,
  output logic [2:0]                            out_row_idx,
  output logic                                  block_done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
  output logic [BLK_CNT_W-1:0]                  blk_cnt,
  output logic                                  busy,
  output logic                                  err_ovf
);

  import dct_pkg::*;

  localparam int               INF_W      = $clog2(MAX_INFLIGHT + 1);
  localparam int               GAP_W      = 8;
  // The accept cycle and the cycle that sees gap_cnt == 0 both count toward
  // the period, so the down-counter reloads with two less than the gap.
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(ROW_GAP - 2);
  localparam logic [2:0]       LAST_ROW   = 3'(ROWS_PER_BLK - 1);

  seq_state_e       state;
  logic [2:0]       row_idx;
  logic [GAP_W-1:0] gap_cnt;

  logic accept;
  logic blk_open;
  logic blk_release;
  logic credit_avail;
  logic has_blk;

  assign in_ready    = (state == ISSUE);
  assign accept      = in_ready && in_valid;
  assign blk_open    = accept && (row_idx == 3'd0);
  assign blk_release = col_en && (out_row_idx == LAST_ROW) && has_blk;
  assign busy        = (inflight != '0) || (row_idx != 3'd0);

  // Row-issue FSM: capture the row, pulse start, then enforce the row period.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      row_idx   <= 3'd0;
      gap_cnt   <= '0;
      dct_start <= 1'b0;
      dct_data  <= '0;
    end else begin
      dct_start <= 1'b0;
      case (state)
        IDLE: begin
          if (credit_avail) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (in_valid) begin
            dct_data  <= in_data;
            dct_start <= 1'b1;
            row_idx   <= next_row(row_idx);
            gap_cnt   <= GAP_RELOAD;
            state     <= SPACE;
          end
        end
        SPACE: begin
          if (gap_cnt == '0) begin
            // Mid-block rows never need a new credit; only block starts do.
            if ((row_idx != 3'd0) || credit_avail) begin
              state <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Column-stage tracking: output row position, completion pulse and count.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      out_row_idx <= 3'd0;
      block_done  <= 1'b0;
      blk_cnt     <= '0;
    end else begin
      block_done <= blk_release;
      if (col_en) begin
        out_row_idx <= next_row(out_row_idx);
      end
      if (blk_release) begin
        blk_cnt <= blk_cnt + BLK_CNT_W'(1);
      end
    end
  end

  dct_blk_credit #(
    .MAX_BLK (MAX_INFLIGHT),
    .CNT_W   (INF_W)
  ) u_credit (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .blk_open     (blk_open),
    .blk_close    (blk_release),
    .consume_evt  (col_en),
    .inflight     (inflight),
    .credit_avail (credit_avail),
    .has_blk      (has_blk),
    .err_ovf      (err_ovf)
  );

endmodule

// File: tb/tb_dct_2d_seq_ctrl.sv
// Directed bench for dct_2d_seq_ctrl: a negedge monitor keeps a scoreboard of
// accepted rows and checks each start pulse against it; the main sequence
// exercises credit, completion, overflow and reset behaviour.
module tb_dct_2d_seq_ctrl;

  localparam int ROW_W        = 96;
  localparam int ROW_GAP      = 8;
  localparam int MAX_INFLIGHT = 2;
  localparam int BLK_CNT_W    = 16;

  logic                 sys_clk;
  logic                 sys_rst_n;
  logic                 in_valid;
  logic [ROW_W-1:0]     in_data;
  logic                 in_ready;
  logic                 dct_start;
  logic [ROW_W-1:0]     dct_data;
  logic                 col_en;
  logic [2:0]           out_row_idx;
  logic                 block_done;
  logic [1:0]           inflight;
  logic [BLK_CNT_W-1:0] blk_cnt;
  logic                 busy;
  logic                 err_ovf;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int acc_total = 0;

  logic [ROW_W-1:0] q_data[$];
  int               q_edge[$];
  int               acc_log[$];

  logic [ROW_W-1:0] exp_d;
  int               exp_e;
  logic [ROW_W-1:0] last_start_data = '0;
  bit               prev_start = 0;
  bit               have_prev  = 0;
  int               prev_acc   = 0;

  dct_2d_seq_ctrl #(
    .ROW_W        (ROW_W),
    .ROW_GAP      (ROW_GAP),
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .BLK_CNT_W    (BLK_CNT_W)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .dct_start   (dct_start),
    .dct_data    (dct_data),
    .col_en      (col_en),
    .out_row_idx (out_row_idx),
    .block_done  (block_done),
    .inflight    (inflight),
    .blk_cnt     (blk_cnt),
    .busy        (busy),
    .err_ovf     (err_ovf)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Offer n distinct rows; gappy toggles in_valid every 3 cycles.
  task automatic send_rows(input int n, input bit gappy);
    int sent   = 0;
    int phase  = 0;
    int budget = n * ROW_GAP * 4 + 50;
    bit hs;
    in_data  = rand_row();
    in_valid = 1'b1;
    while (sent < n && budget > 0) begin
      @(negedge sys_clk);
      hs = in_valid && in_ready;
      @(posedge sys_clk);
      #1;
      budget--;
      if (hs) begin
        sent++;
        in_data = rand_row();
      end
      if (gappy) begin
        phase++;
        if (phase == 3) begin
          phase    = 0;
          in_valid = !in_valid;
        end
      end
    end
    in_valid = 1'b0;
    chk("send_rows_count", sent, n);
  endtask

  task automatic pulse_col(input int n);
    repeat (n) begin
      col_en = 1'b1;
      step(1);
      col_en = 1'b0;
      step(1);
    end
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      q_data.delete();
      q_edge.delete();
      have_prev       = 0;
      prev_start      = 0;
      last_start_data = '0;
    end else begin
      if (dct_start) begin
        chk("start_single", prev_start, 1'b0);
        chk("sb_nonempty", q_data.size() != 0, 1'b1);
        if (q_data.size() != 0) begin
          exp_d = q_data.pop_front();
          exp_e = q_edge.pop_front();
          chk("dct_data", dct_data, exp_d);
          chk("start_latency", cyc, exp_e);
          last_start_data = exp_d;
        end
      end else begin
        chk("dct_data_hold", dct_data, last_start_data);
      end
      prev_start = dct_start;
      if (in_valid && in_ready) begin
        if (have_prev) chk("acc_gap_min", (cyc + 1 - prev_acc) >= ROW_GAP, 1'b1);
        have_prev = 1;
        prev_acc  = cyc + 1;
        q_data.push_back(in_data);
        q_edge.push_back(cyc + 1);
        acc_log.push_back(cyc + 1);
        acc_total++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    col_en    = 1'b0;
    step(2);

    // Reset state
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_dct_start", dct_start, 1'b0);
    chk("rst_dct_data", dct_data, '0);
    chk("rst_block_done", block_done, 1'b0);
    chk("rst_inflight", inflight, 2'd0);
    chk("rst_blk_cnt", blk_cnt, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_ovf", err_ovf, 1'b0);
    chk("rst_out_row_idx", out_row_idx, 3'd0);
    sys_rst_n = 1'b1;
    step(3);

    // Overflow: column beat with nothing in flight
    col_en = 1'b1;
    step(1);
    col_en = 1'b0;
    chk("ovf_set", err_ovf, 1'b1);
    chk("ovf_inflight", inflight, 2'd0);
    chk("ovf_row_adv", out_row_idx, 3'd1);
    step(5);
    chk("ovf_sticky", err_ovf, 1'b1);
    sys_rst_n = 1'b0;
    step(1);
    sys_rst_n = 1'b1;
    chk("ovf_cleared", err_ovf, 1'b0);
    chk("ovf_row_cleared", out_row_idx, 3'd0);

    // Single block, valid held high: exact row period
    acc_log.delete();
    send_rows(8, 1'b0);
    chk("blk1_accepts", acc_log.size(), 8);
    for (int i = 1; i < acc_log.size(); i++) chk("blk1_spacing", acc_log[i] - acc_log[i-1], ROW_GAP);
    chk("blk1_inflight", inflight, 2'd1);
    chk("blk1_busy", busy, 1'b1);
    step(3);
    pulse_col(7);
    chk("blk1_row7", out_row_idx, 3'd7);
    chk("blk1_no_done_yet", block_done, 1'b0);
    col_en = 1'b1;
    step(1);
    col_en = 1'b0;
    chk("blk1_done", block_done, 1'b1);
    chk("blk1_blk_cnt", blk_cnt, 16'd1);
    chk("blk1_inflight_0", inflight, 2'd0);
    chk("blk1_row_wrap", out_row_idx, 3'd0);
    step(1);
    chk("blk1_done_pulse", block_done, 1'b0);
    chk("blk1_idle_busy", busy, 1'b0);

    // Credit stall: two blocks fill both banks
    send_rows(16, 1'b0);
    chk("stall_inflight", inflight, 2'd2);
    in_data  = rand_row();
    in_valid = 1'b1;
    a0 = acc_total;
    step(40);
    chk("stall_no_accept", acc_total, a0);
    chk("stall_in_ready", in_ready, 1'b0);
    pulse_col(7);
    col_en = 1'b1;
    step(1);
    col_en = 1'b0;
    chk("stall_done", block_done, 1'b1);
    chk("stall_inflight_1", inflight, 2'd1);
    chk("stall_blk_cnt", blk_cnt, 16'd2);
    step(2);
    chk("stall_resume_accept", acc_total, a0 + 1);
    chk("stall_inflight_2", inflight, 2'd2);
    in_valid = 1'b0;
    send_rows(7, 1'b0);
    pulse_col(8);
    chk("stall_drain_cnt", blk_cnt, 16'd3);
    chk("stall_drain_inflight", inflight, 2'd1);

    // Block completion on the same edge as a new block start
    pulse_col(7);
    chk("sim_row7", out_row_idx, 3'd7);
    chk("sim_ready", in_ready, 1'b1);
    a0 = acc_total;
    in_data  = rand_row();
    in_valid = 1'b1;
    col_en   = 1'b1;
    step(1);
    in_valid = 1'b0;
    col_en   = 1'b0;
    chk("sim_accept", acc_total, a0 + 1);
    chk("sim_inflight", inflight, 2'd1);
    chk("sim_blk_cnt", blk_cnt, 16'd4);
    chk("sim_done", block_done, 1'b1);
    send_rows(7, 1'b0);
    pulse_col(8);
    chk("sim_drain_inflight", inflight, 2'd0);
    chk("sim_drain_cnt", blk_cnt, 16'd5);

    // Upstream gaps
    acc_log.delete();
    send_rows(8, 1'b1);
    chk("gap_accepts", acc_log.size(), 8);
    for (int i = 1; i < acc_log.size(); i++) chk("gap_spacing", (acc_log[i] - acc_log[i-1]) >= ROW_GAP, 1'b1);
    chk("gap_inflight", inflight, 2'd1);

    // Reset in the middle of a block
    send_rows(4, 1'b0);
    chk("mid_inflight", inflight, 2'd2);
    step(3);
    chk("mid_sb_drained", q_data.size(), 0);
    sys_rst_n = 1'b0;
    step(1);
    sys_rst_n = 1'b1;
    chk("mrst_in_ready", in_ready, 1'b0);
    chk("mrst_dct_start", dct_start, 1'b0);
    chk("mrst_dct_data", dct_data, '0);
    chk("mrst_inflight", inflight, 2'd0);
    chk("mrst_blk_cnt", blk_cnt, '0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_block_done", block_done, 1'b0);
    chk("mrst_out_row_idx", out_row_idx, 3'd0);
    acc_log.delete();
    send_rows(8, 1'b0);
    for (int i = 1; i < acc_log.size(); i++) chk("mrst_spacing", acc_log[i] - acc_log[i-1], ROW_GAP);
    step(3);
    chk("mrst_one_block", inflight, 2'd1);
    pulse_col(8);
    chk("mrst_blk_cnt_1", blk_cnt, 16'd1);
    chk("mrst_inflight_0", inflight, 2'd0);
    chk("mrst_row_idx_0", busy, 1'b0);

    step(2);
    chk("final_sb_empty", q_data.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
